// File: rtl/sram_bist_ctrl_if.sv
// SRAM test port plus BIST control/status, shared by the BIST controller
// (master) and the SRAM/functional side (slave).
interface sram_bist_ctrl_if #(
  parameter int DW = 5,
  parameter int AW = 5
);
  logic          start;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_count;

  modport master (
    input  start, mem_rdata,
    output mem_wr_en, mem_addr, mem_wdata, busy, done, pass, fail_addr, err_count
  );

  modport slave (
    output start, mem_rdata,
    input  mem_wr_en, mem_addr, mem_wdata, busy, done, pass, fail_addr, err_count
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// March-style BIST initiator for a single-port SRAM with registered read data.
// Runs up(w BG), up(r BG, w ~BG), down(r ~BG, w BG), up(r BG) and reports.
//
// state  | meaning
// IDLE   | waiting for start, port idle
// M0_WR  | write BG, address counting up
// M1_RD  | present read, ascending
// M1_WR  | check BG, write ~BG to same address
// M2_RD  | present read, descending
// M2_WR  | check ~BG, write BG to same address
// M3_RD  | present read, ascending
// M3_CMP | check BG
// DONE   | results valid, port idle
module sram_bist_ctrl #(
  parameter int              DW = 5,
  parameter int              AW = 5,
  parameter logic [DW-1:0]   BG = '0
) (
  input  logic            clk,
  input  logic            rst,
  sram_bist_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, M0_WR, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CMP, DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [7:0]    err_cnt, err_nxt;
  logic [AW-1:0] fail_q, fail_nxt;
  logic          cmp_en;
  logic [DW-1:0] exp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      err_cnt <= '0;
      fail_q  <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      err_cnt <= err_nxt;
      fail_q  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    err_nxt       = err_cnt;
    fail_nxt      = fail_q;
    cmp_en        = 1'b0;
    exp_data      = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = M0_WR;
          addr_nxt  = '0;
          err_nxt   = '0;
          fail_nxt  = '0;
        end
      end
      M0_WR: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = BG;
        addr_nxt      = addr + ADDR_ONE;
        if (addr == ADDR_LAST) begin
          state_nxt = M1_RD;
          addr_nxt  = '0;
        end
      end
      M1_RD: state_nxt = M1_WR;
      M1_WR: begin
        cmp_en        = 1'b1;
        exp_data      = BG;
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = ~BG;
        if (addr == ADDR_LAST) begin
          state_nxt = M2_RD;
        end else begin
          state_nxt = M1_RD;
          addr_nxt  = addr + ADDR_ONE;
        end
      end
      M2_RD: state_nxt = M2_WR;
      M2_WR: begin
        cmp_en        = 1'b1;
        exp_data      = ~BG;
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = BG;
        if (addr == '0) begin
          state_nxt = M3_RD;
        end else begin
          state_nxt = M2_RD;
          addr_nxt  = addr - ADDR_ONE;
        end
      end
      M3_RD: state_nxt = M3_CMP;
      M3_CMP: begin
        cmp_en   = 1'b1;
        exp_data = BG;
        if (addr == ADDR_LAST) begin
          state_nxt = DONE;
          addr_nxt  = '0;
        end else begin
          state_nxt = M3_RD;
          addr_nxt  = addr + ADDR_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Only the first mismatch records its address; the count saturates.
    if (cmp_en && (bus.mem_rdata != exp_data)) begin
      if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
      if (err_cnt == 8'd0) fail_nxt = addr;
    end
  end

  assign bus.busy      = (state != IDLE) && (state != DONE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err_cnt == 8'd0);
  assign bus.mem_addr  = bus.busy ? addr : '0;
  assign bus.fail_addr = fail_q;
  assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Scoreboard bench for sram_bist_ctrl: two controllers (BG=0 and BG=01010)
// each beside a behavioural SRAM with selectable faults.
module tb_sram_bist_ctrl;
  localparam int DW = 5;
  localparam int AW = 5;
  localparam logic [4:0] BG_A = 5'b00000;
  localparam logic [4:0] BG_B = 5'b01010;

  typedef enum int {F_NONE, F_STUCK7, F_IGN31, F_ALL0} fault_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sram_bist_ctrl_if #(.DW(DW), .AW(AW)) ifa ();
  sram_bist_ctrl_if #(.DW(DW), .AW(AW)) ifb ();

  sram_bist_ctrl #(.DW(DW), .AW(AW), .BG(BG_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  sram_bist_ctrl #(.DW(DW), .AW(AW), .BG(BG_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  always #5 clk = ~clk;

  // Behavioural SRAMs: write on wr_en, otherwise registered read.
  logic [4:0] mem_a [32];
  logic [4:0] mem_b [32];
  fault_t fault_a = F_NONE;
  fault_t fault_b = F_ALL0;

  function automatic logic [4:0] rd_fault(input fault_t f, input logic [4:0] a, input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (f == F_STUCK7 && a == 5'd7) r[2] = 1'b1;
    if (f == F_ALL0) r = 5'b00000;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 5'd0;
        mem_b[i] <= 5'd0;
      end
    end else begin
      if (ifa.mem_wr_en) begin
        if (!(fault_a == F_IGN31 && ifa.mem_addr == 5'd31)) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
      end else begin
        ifa.mem_rdata <= rd_fault(fault_a, ifa.mem_addr, mem_a[ifa.mem_addr]);
      end
      if (ifb.mem_wr_en) begin
        if (!(fault_b == F_IGN31 && ifb.mem_addr == 5'd31)) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
      end else begin
        ifb.mem_rdata <= rd_fault(fault_b, ifb.mem_addr, mem_b[ifb.mem_addr]);
      end
    end
  end

  // Scoreboard queues: port entries {wr, addr, wdata}, results {pass, err, fail_addr}.
  logic [10:0] port_qa[$];
  logic [10:0] port_qb[$];
  logic [13:0] res_qa[$];
  logic [13:0] res_qb[$];
  int          busy_cyc [2];
  logic [1:0]  busy_prev = 2'b00;
  logic [1:0]  done_prev = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_port(input int s, input logic wr, input logic [4:0] a, input logic [4:0] wd);
    if (s == 0) port_qa.push_back({wr, a, wd});
    else        port_qb.push_back({wr, a, wd});
  endtask

  // Expected port trace of one full March run plus the final result.
  task automatic push_run(input int s, input logic pass_e, input logic [7:0] err_e, input logic [4:0] fail_e);
    logic [4:0] bg;
    bg = (s == 0) ? BG_A : BG_B;
    for (int a = 0; a < 32; a++) push_port(s, 1'b1, 5'(a), bg);
    for (int a = 0; a < 32; a++) begin
      push_port(s, 1'b0, 5'(a), 5'd0);
      push_port(s, 1'b1, 5'(a), ~bg);
    end
    for (int a = 31; a >= 0; a--) begin
      push_port(s, 1'b0, 5'(a), 5'd0);
      push_port(s, 1'b1, 5'(a), bg);
    end
    for (int a = 0; a < 32; a++) begin
      push_port(s, 1'b0, 5'(a), 5'd0);
      push_port(s, 1'b0, 5'(a), 5'd0);
    end
    if (s == 0) res_qa.push_back({pass_e, err_e, fail_e});
    else        res_qb.push_back({pass_e, err_e, fail_e});
  endtask

  task automatic monitor(input int s, input logic busy, input logic wr, input logic [4:0] addr,
                         input logic [4:0] wd, input logic done, input logic pass,
                         input logic [7:0] err, input logic [4:0] fail);
    string       p;
    logic [10:0] e;
    logic [13:0] r;
    int          qn;
    p = (s == 0) ? "a" : "b";
    if (busy) begin
      busy_cyc[s] = busy_prev[s] ? busy_cyc[s] + 1 : 1;
      qn = (s == 0) ? port_qa.size() : port_qb.size();
      if (qn == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_port: port active at addr %0d with no expected entry", p, addr);
      end else begin
        e = (s == 0) ? port_qa.pop_front() : port_qb.pop_front();
        // write data is only meaningful on write cycles
        if (e[10]) check({p, "_port"}, 32'({wr, addr, wd}), 32'(e));
        else       check({p, "_port"}, 32'({wr, addr, 5'd0}), 32'({e[10:5], 5'd0}));
      end
    end
    if (done && !done_prev[s]) begin
      qn = (s == 0) ? res_qa.size() : res_qb.size();
      if (qn == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_done: done rose with no expected result", p);
      end else begin
        r = (s == 0) ? res_qa.pop_front() : res_qb.pop_front();
        check({p, "_pass"}, 32'(pass), 32'(r[13]));
        check({p, "_err_count"}, 32'(err), 32'(r[12:5]));
        check({p, "_fail_addr"}, 32'(fail), 32'(r[4:0]));
        check({p, "_busy_cycles"}, 32'(busy_cyc[s]), 32'd224);
      end
    end
    busy_prev[s] = busy;
    done_prev[s] = done;
  endtask

  always @(negedge clk) begin
    monitor(0, ifa.busy, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata, ifa.done, ifa.pass, ifa.err_count, ifa.fail_addr);
    monitor(1, ifb.busy, ifb.mem_wr_en, ifb.mem_addr, ifb.mem_wdata, ifb.done, ifb.pass, ifb.err_count, ifb.fail_addr);
  end

  task automatic pulse_start(input int s);
    if (s == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done(input int s, input int limit);
    int n;
    n = 0;
    while (((s == 0) ? ifa.done : ifb.done) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (((s == 0) ? ifa.done : ifb.done) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done_%0d: done not seen within %0d cycles", s, limit);
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a_outs", 32'({ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata, ifa.busy, ifa.done, ifa.pass}), 32'd0);
    check("reset_a_results", 32'({ifa.fail_addr, ifa.err_count}), 32'd0);
    check("reset_b_outs", 32'({ifb.mem_wr_en, ifb.mem_addr, ifb.mem_wdata, ifb.busy, ifb.done, ifb.pass}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run on A, with a start pulse during M1 that must be ignored.
    fault_a = F_NONE;
    push_run(0, 1'b1, 8'd0, 5'd0);
    pulse_start(0);
    check("start_latency_busy", 32'(ifa.busy), 32'd1);
    repeat (50) @(negedge clk);
    pulse_start(0);
    wait_done(0, 300);

    // Address 7 bit 2 stuck-at-1: M1 and M3 reads fail.
    fault_a = F_STUCK7;
    push_run(0, 1'b0, 8'd2, 5'd7);
    pulse_start(0);
    wait_done(0, 300);

    // Start from DONE clears the results and reruns.
    fault_a = F_NONE;
    push_run(0, 1'b1, 8'd0, 5'd0);
    ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    check("rerun_cleared", 32'({ifa.done, ifa.pass, ifa.err_count, ifa.fail_addr}), 32'd0);
    check("rerun_busy", 32'(ifa.busy), 32'd1);
    @(negedge clk);
    wait_done(0, 300);

    // Address 31 ignores writes: only its M2 read fails.
    fault_a = F_IGN31;
    push_run(0, 1'b0, 8'd1, 5'd31);
    pulse_start(0);
    wait_done(0, 300);
    fault_a = F_NONE;

    // B: every word reads 0 with BG=01010, 96 failures.
    push_run(1, 1'b0, 8'd96, 5'd0);
    pulse_start(1);
    wait_done(1, 300);

    // Reset during M2, then a clean run.
    push_run(0, 1'b1, 8'd0, 5'd0);
    pulse_start(0);
    repeat (110) @(negedge clk);
    check("pre_reset_busy", 32'(ifa.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset_outs", 32'({ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata, ifa.busy, ifa.done, ifa.pass}), 32'd0);
    check("midreset_results", 32'({ifa.fail_addr, ifa.err_count}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_wr_en", 32'(ifa.mem_wr_en), 32'd0);
    end
    port_qa.delete();
    res_qa.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'({ifa.busy, ifa.done, ifa.mem_wr_en}), 32'd0);
    push_run(0, 1'b1, 8'd0, 5'd0);
    pulse_start(0);
    wait_done(0, 300);

    repeat (2) @(negedge clk);
    check("port_q_a_drained", 32'(port_qa.size()), 32'd0);
    check("port_q_b_drained", 32'(port_qb.size()), 32'd0);
    check("res_q_drained", 32'(res_qa.size() + res_qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
